// File: rtl/motctl_arbiter.sv
// motctl_arbiter: shares BOTSIM MotCtl_in between a high-priority gesture channel (G) and a
// low-priority autonomous channel (A), switching only on upd_sysregs ticks. Optional macro: MOTCTL_SOFT_STOP_EN.
module motctl_arbiter #(
   parameter int TIMEOUT_TICKS = 16,
   parameter int MIN_HOLD      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       upd_sysregs,
   input  logic       g_req,
   input  logic       g_valid,
   input  logic [7:0] g_cmd,
   output logic       g_gnt,
   input  logic       a_req,
   input  logic       a_valid,
   input  logic [7:0] a_cmd,
   output logic       a_gnt,
   output logic [7:0] motctl_out,
   output logic [1:0] owner,
   output logic       wdog_trip
);
   localparam int              WD_W     = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_TICKS);
   localparam logic [3:0]      HOLD_MAX = 4'(MIN_HOLD);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_OWN_G = 3'd1,
      S_OWN_A = 3'd2,
      S_TRIP  = 3'd3,
      S_STOP  = 3'd4
   } state_t;

`ifdef MOTCTL_SOFT_STOP_EN
   localparam state_t TO_G = S_STOP;
   localparam state_t TO_A = S_STOP;
`else
   localparam state_t TO_G = S_OWN_G;
   localparam state_t TO_A = S_OWN_A;
`endif

   state_t          r_state;
   state_t          w_nxt;
   state_t          w_idle_pick;
   logic            r_trip_g;
   logic [7:0]      r_g_shadow;
   logic [7:0]      r_a_shadow;
   logic [WD_W-1:0] r_wdog_cnt;
   logic [WD_W-1:0] w_wd_inc;
   logic [3:0]      r_hold_cnt;
   logic [3:0]      w_hold_inc;
   logic [7:0]      w_g_cmd;
   logic [7:0]      w_a_cmd;
   logic            w_owning;
   logic            w_own_valid;
   logic            w_expired;

   // A strobe coinciding with a tick bypasses the shadow so the fresh command goes out.
   assign w_g_cmd     = g_valid ? g_cmd : r_g_shadow;
   assign w_a_cmd     = a_valid ? a_cmd : r_a_shadow;
   assign w_owning    = (r_state == S_OWN_G) || (r_state == S_OWN_A);
   assign w_own_valid = ((r_state == S_OWN_G) && g_valid) || ((r_state == S_OWN_A) && a_valid);
   assign w_wd_inc    = r_wdog_cnt + WD_W'(1);
   assign w_expired   = w_owning && !w_own_valid && (w_wd_inc == WD_LIMIT);
   assign w_hold_inc  = (r_hold_cnt >= HOLD_MAX) ? HOLD_MAX : (r_hold_cnt + 4'd1);

   // Next-state selection, only committed on ticks; preemption uses the count including this tick.
   always_comb begin
      if (g_req) begin
         w_idle_pick = S_OWN_G;
      end else if (a_req) begin
         w_idle_pick = S_OWN_A;
      end else begin
         w_idle_pick = S_IDLE;
      end
      w_nxt = r_state;
      case (r_state)
         S_IDLE, S_STOP: w_nxt = w_idle_pick;
         S_OWN_G: begin
            if (w_expired) begin
               w_nxt = S_TRIP;
            end else if (!g_req) begin
               w_nxt = a_req ? TO_A : S_IDLE;
            end else begin
               w_nxt = S_OWN_G;
            end
         end
         S_OWN_A: begin
            if (w_expired) begin
               w_nxt = S_TRIP;
            end else if (!a_req) begin
               w_nxt = g_req ? TO_G : S_IDLE;
            end else if (g_req && (w_hold_inc >= HOLD_MAX)) begin
               w_nxt = TO_G;
            end else begin
               w_nxt = S_OWN_A;
            end
         end
         S_TRIP: begin
            if (r_trip_g ? !g_req : !a_req) begin
               w_nxt = S_IDLE;
            end else begin
               w_nxt = S_TRIP;
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   // State, counters, shadows and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_trip_g   <= 1'b0;
         r_g_shadow <= 8'h00;
         r_a_shadow <= 8'h00;
         r_wdog_cnt <= {WD_W{1'b0}};
         r_hold_cnt <= 4'd0;
         motctl_out <= 8'h00;
         g_gnt      <= 1'b0;
         a_gnt      <= 1'b0;
         owner      <= 2'b00;
         wdog_trip  <= 1'b0;
      end else begin
         if (g_valid) r_g_shadow <= g_cmd;
         if (a_valid) r_a_shadow <= a_cmd;
         if (upd_sysregs) begin
            r_state <= w_nxt;
            if ((w_nxt == S_TRIP) && (r_state != S_TRIP)) r_trip_g <= (r_state == S_OWN_G);
            r_hold_cnt <= ((r_state == S_OWN_A) && (w_nxt == S_OWN_A)) ? w_hold_inc : 4'd0;
            r_wdog_cnt <= (w_owning && (w_nxt == r_state) && !w_own_valid) ? w_wd_inc : {WD_W{1'b0}};
            case (w_nxt)
               S_OWN_G: begin
                  motctl_out <= w_g_cmd;
                  g_gnt      <= 1'b1;
                  a_gnt      <= 1'b0;
                  owner      <= 2'b01;
                  wdog_trip  <= 1'b0;
               end
               S_OWN_A: begin
                  motctl_out <= w_a_cmd;
                  g_gnt      <= 1'b0;
                  a_gnt      <= 1'b1;
                  owner      <= 2'b10;
                  wdog_trip  <= 1'b0;
               end
               S_TRIP: begin
                  motctl_out <= 8'h00;
                  g_gnt      <= 1'b0;
                  a_gnt      <= 1'b0;
                  owner      <= 2'b11;
                  wdog_trip  <= 1'b1;
               end
               default: begin
                  motctl_out <= 8'h00;
                  g_gnt      <= 1'b0;
                  a_gnt      <= 1'b0;
                  owner      <= 2'b00;
                  wdog_trip  <= 1'b0;
               end
            endcase
         end else if (w_own_valid) begin
            r_wdog_cnt <= {WD_W{1'b0}};
         end
      end
   end
endmodule

// File: tb/tb_motctl_arbiter.sv
// Randomised + directed bench for motctl_arbiter: a tick-level owner model feeds a scoreboard queue,
// and a monitor compares the DUT outputs every cycle against the latest expected tick result.
module tb_motctl_arbiter;
   localparam int TIMEOUT  = 16;
   localparam int MIN_HOLD = 2;

`ifdef MOTCTL_SOFT_STOP_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       upd_sysregs = 1'b0;
   logic       g_req = 1'b0, g_valid = 1'b0, a_req = 1'b0, a_valid = 1'b0;
   logic [7:0] g_cmd = 8'h00, a_cmd = 8'h00;
   logic       g_gnt, a_gnt, wdog_trip;
   logic [7:0] motctl_out;
   logic [1:0] owner;

   always #5 clk = ~clk;

   motctl_arbiter #(.TIMEOUT_TICKS(TIMEOUT), .MIN_HOLD(MIN_HOLD)) dut (
      .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs),
      .g_req(g_req), .g_valid(g_valid), .g_cmd(g_cmd), .g_gnt(g_gnt),
      .a_req(a_req), .a_valid(a_valid), .a_cmd(a_cmd), .a_gnt(a_gnt),
      .motctl_out(motctl_out), .owner(owner), .wdog_trip(wdog_trip)
   );

   int          checks = 0;
   int          errors = 0;
   logic [12:0] exp_q[$];
   logic [12:0] exp_cur = 13'd0;
   bit          mon_en = 1'b0;

   // Reference model: owner 0 none, 1 G, 2 A, 3 tripped, 4 soft stop.
   int         m_own, m_who, m_quiet, m_held;
   logic [7:0] m_gsh, m_ash;

   function automatic int handoff(int target);
      return SOFT ? 4 : target;
   endfunction

   function automatic logic [12:0] pack_out(int own, logic [7:0] g, logic [7:0] a);
      case (own)
         1:       return {g, 1'b1, 1'b0, 2'b01, 1'b0};
         2:       return {a, 1'b0, 1'b1, 2'b10, 1'b0};
         3:       return {8'h00, 1'b0, 1'b0, 2'b11, 1'b1};
         default: return 13'd0;
      endcase
   endfunction

   function void model_reset();
      m_own = 0; m_who = 0; m_quiet = 0; m_held = 0;
      m_gsh = 8'h00; m_ash = 8'h00;
   endfunction

   function void model_step();
      bit refresh;
      int nxt;
      if (g_valid) m_gsh = g_cmd;
      if (a_valid) m_ash = a_cmd;
      refresh = (m_own == 1 && g_valid) || (m_own == 2 && a_valid);
      if (!upd_sysregs) begin
         if (refresh) m_quiet = 0;
         return;
      end
      if (m_own == 1 || m_own == 2) m_quiet = refresh ? 0 : m_quiet + 1;
      case (m_own)
         1: begin
            if (m_quiet == TIMEOUT) nxt = 3;
            else if (!g_req) nxt = a_req ? handoff(2) : 0;
            else nxt = 1;
         end
         2: begin
            m_held++;
            if (m_quiet == TIMEOUT) nxt = 3;
            else if (!a_req) nxt = g_req ? handoff(1) : 0;
            else if (g_req && m_held >= MIN_HOLD) nxt = handoff(1);
            else nxt = 2;
         end
         3: nxt = ((m_who == 1) ? g_req : a_req) ? 3 : 0;
         default: nxt = g_req ? 1 : (a_req ? 2 : 0);
      endcase
      if (nxt != m_own) begin
         m_quiet = 0;
         m_held  = 0;
         if (nxt == 3) m_who = m_own;
      end
      m_own = nxt;
      exp_q.push_back(pack_out(nxt, m_gsh, m_ash));
   endfunction

   task automatic compare(string name, logic [12:0] exp);
      logic [12:0] act;
      act = {motctl_out, g_gnt, a_gnt, owner, wdog_trip};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got motctl=%h g_gnt=%b a_gnt=%b owner=%b trip=%b, expected motctl=%h g_gnt=%b a_gnt=%b owner=%b trip=%b",
                  name, $time, act[12:5], act[4], act[3], act[2:1], act[0],
                  exp[12:5], exp[4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   // Monitor: a tick at the last edge makes the DUT present a new result; check every cycle.
   initial begin
      bit t;
      forever begin
         @(posedge clk);
         t = upd_sysregs && reset;
         @(negedge clk);
         if (mon_en) begin
            if (t) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard_underflow @%0t: got empty queue, expected an entry", $time);
               end else begin
                  exp_cur = exp_q.pop_front();
               end
            end
            compare("outputs", exp_cur);
         end
      end
   end

   task automatic cyc(bit upd, bit gr, bit ar, bit gv, logic [7:0] gc, bit av, logic [7:0] ac);
      upd_sysregs = upd; g_req = gr; a_req = ar;
      g_valid = gv; g_cmd = gc; a_valid = av; a_cmd = ac;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n, bit gr, bit ar);
      for (int i = 0; i < n; i++) cyc(1'b0, gr, ar, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic tk(bit gr, bit ar);
      cyc(1'b1, gr, ar, 1'b0, 8'h00, 1'b0, 8'h00);
      idle(1, gr, ar);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      reset  = 1'b0;
      #2;
      upd_sysregs = 1'b0; g_req = 1'b0; a_req = 1'b0;
      g_valid = 1'b0; a_valid = 1'b0; g_cmd = 8'h00; a_cmd = 8'h00;
      compare("async_reset", 13'd0);
      exp_q.delete();
      model_reset();
      exp_cur = 13'd0;
      @(posedge clk);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin
      bit gr, ar;
      int vprob;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // A gets the bot with a command loaded before the tick.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33);
      tk(1'b0, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Simultaneous requests: G wins, same-cycle strobes bypass the shadows.
      do_reset();
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h33);
      idle(2, 1'b1, 1'b1);

      // Preemption respects the minimum hold of A.
      do_reset();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C);
      tk(1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00);
      tk(1'b1, 1'b1);
      tk(1'b1, 1'b1);
      tk(1'b1, 1'b1);

      // A starves its watchdog: trip after 16 ticks, release by dropping a_req.
      do_reset();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h21);
      tk(1'b0, 1'b1);
      for (int i = 0; i < TIMEOUT; i++) tk(1'b0, 1'b1);
      tk(1'b0, 1'b1);
      tk(1'b0, 1'b0);
      tk(1'b0, 1'b0);

      // Owner strobe on a tick refreshes output and watchdog; then a valid on the expiring tick.
      do_reset();
      tk(1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h00);
      for (int i = 0; i < TIMEOUT - 1; i++) tk(1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
      for (int i = 0; i < TIMEOUT; i++) tk(1'b1, 1'b0);

      // Non-owner strobes do not feed the watchdog; trip blocks A until G drops.
      do_reset();
      tk(1'b1, 1'b0);
      for (int i = 0; i < TIMEOUT; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'(i));
         tk(1'b1, 1'b1);
      end
      tk(1'b1, 1'b1);
      tk(1'b0, 1'b1);
      tk(1'b0, 1'b1);

      // G releases while A waits (direct handover or one stop tick), then reset mid-ownership.
      do_reset();
      tk(1'b1, 1'b1);
      tk(1'b0, 1'b1);
      tk(1'b0, 1'b1);
      tk(1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      do_reset();

      // Randomised phases with different strobe densities.
      gr = 1'b0;
      ar = 1'b0;
      for (int ph = 0; ph < 3; ph++) begin
         vprob = (ph == 0) ? 4 : ((ph == 1) ? 30 : 200);
         for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(15) == 0) gr = ~gr;
            if ($urandom_range(11) == 0) ar = ~ar;
            if ($urandom_range(700) == 0) begin
               do_reset();
            end else begin
               cyc($urandom_range(2) == 0, gr, ar,
                   $urandom_range(vprob) == 0, 8'($urandom),
                   $urandom_range(vprob) == 0, 8'($urandom));
            end
         end
      end
      idle(3, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
